muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit that owns the HI/LO register pair for the multicycle MIPS datapath. It replaces the single-cycle HI path through the ALU with a parametrised, width-generic sequential engine. The engine runs signed or unsigned MULT/DIV over WIDTH+2 cycles behind a start/busy/done handshake. The control unit issues an operation, stalls on `busy`, and reads `hi`/`lo` through MUXA exactly as it reads the Hi/Lo registers today.

## Interface
- `WIDTH`, 32, operand and result width in bits; legal values are even and ≥ 4.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  launches the operation on `op` with operands `a`, `b`; honoured only while idle.
- `op`  in  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a`  in  WIDTH  operand rs; captured on the accepting edge.
- `b`  in  WIDTH  operand rt; captured on the accepting edge.
- `hi_wr`  in  1  MTHI: load `wr_data` into HI; honoured only while idle.
- `lo_wr`  in  1  MTLO: load `wr_data` into LO; honoured only while idle.
- `wr_data`  in  WIDTH  data for MTHI/MTLO.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse in the cycle HI/LO first show the new result.
- `div_by_zero`  out  1  sticky flag; set by DIV/DIVU with b==0, cleared by the next accepted start.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- State machine states:
  - IDLE: accepts `start`, `hi_wr`, `lo_wr`.
  - CALC: runs WIDTH iterations; a counter of width clog2(WIDTH)+1 counts up from 0.
  - FIX: applies sign correction, writes HI/LO, pulses `done`, returns to IDLE.
- Operand capture in IDLE with `start`=1:
  - For signed ops, store |a|, |b| and sign bits sa, sb.
  - For unsigned ops, store a, b as-is.
  - Go to CALC, except DIV/DIVU with b==0, which go directly to FIX.
- Multiply, radix-2 shift-add:
  - Uses a 2·WIDTH-bit product accumulator.
  - Each iteration: if the multiplier LSB is 1, add the multiplicand to the upper half; then shift the whole accumulator right by one, with the carry entering at the MSB.
- Divide, restoring:
  - Uses a WIDTH+1-bit partial remainder.
  - Each iteration: shift {rem, dividend} left by one; subtract the divisor; if the result is non-negative keep it and set the quotient bit to 1, else restore.
- FIX, multiply:
  - For MULT with sa^sb, negate the 2·WIDTH product (two's complement).
  - {hi,lo} = product.
- FIX, divide:
  - lo = quotient, hi = remainder.
  - For DIV, negate the quotient if sa^sb, and negate the remainder if sa (remainder takes the sign of the dividend).
- Divide-by-zero result:
  - hi = a (raw), lo = all-ones, `div_by_zero`=1.
- Signed overflow:
  - DIV of the most-negative value by −1 gives lo = most-negative value, hi = 0, with no flag (wrap).
- Handshake priority:
  - `start` while busy is ignored (no queueing).
  - `hi_wr`/`lo_wr` while busy are ignored.
  - `start` together with `hi_wr`/`lo_wr` in IDLE: `start` wins and the writes are dropped.
  - `hi_wr` and `lo_wr` together: both load `wr_data`.
- Reset (including mid-operation):
  - State → IDLE; hi, lo, `busy`, `done`, `div_by_zero` → 0; the counter and accumulators are cleared.

## Timing
- Latency, normal operation:
  - Edge E0 accepts `start`.
  - `busy` is high from after E0.
  - Iterations occur at E1..E_WIDTH.
  - FIX executes at E_WIDTH+1.
  - After E_WIDTH+1: hi/lo are valid, `done`=1, `busy`=0.
  - `done` clears after E_WIDTH+2.
  - Total is WIDTH+2 cycles from start to `done` (34 at WIDTH=32).
- Latency, divide by zero:
  - E0 accepts, E1 executes FIX.
  - `done` is high after E1 (2 cycles).
- Back-to-back operation:
  - `start` may be asserted in the `done` cycle, because the machine is already IDLE then. It is accepted at that edge.
- hi/lo hold their previous values for the whole operation. They change only at the FIX edge, or one edge after an honoured MTHI/MTLO.
- `busy` is purely registered; it has no combinational path from `start`.

## Test plan
- Signed multiply, WIDTH=32: MULT a=FFFFFFFD (−3), b=00000005 → `done` exactly 34 cycles after start; hi=FFFFFFFF, lo=FFFFFFF1; `busy` high for 33 cycles.
- Unsigned multiply extremes: MULTU a=b=FFFFFFFF → hi=FFFFFFFE, lo=00000001. Then MULT a=b=80000000 → hi=40000000, lo=00000000.
- Division sign rules:
  - DIV a=FFFFFFF9 (−7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF.
  - DIVU a=100, b=7 → lo=14, hi=2.
  - DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
- Divide by zero:
  - DIVU a=1234, b=0 → `done` 2 cycles after start; hi=1234, lo=FFFFFFFF; `div_by_zero`=1.
  - A following MULTU 2×3 clears the flag; lo=6.
- Handshake and priority:
  - `start` and `hi_wr` pulsed mid-operation → ignored; result unchanged.
  - In IDLE, `start`+`lo_wr` together → only the operation runs.
  - MTHI 0xABCD in IDLE → hi=0xABCD after one edge.
  - `start` in the `done` cycle → second result after another 34 cycles.
- Reset and parametrisation:
  - Assert `reset` at iteration 10 → next edge `busy`=0, hi=lo=0, `done` never pulses.
  - With WIDTH=8: MULT 0x80×0x80 → hi=0x40, lo=0x00; DIV 0x80/0xFF → lo=0x80, hi=0x00; `done` 10 cycles after start.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine owning the HI/LO pair: radix-2 shift-add
// multiply and restoring divide, WIDTH+2 cycles per operation.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    logic [1:0]         op_reg;
    logic               sa_reg, sb_reg, dbz_pend_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quo_reg;
    logic [WIDTH-1:0]   opb_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               busy_reg, done_reg, dbz_reg;

    logic               accept, iterate, fix_now, hi_load, lo_load;

    // Operand conditioning at capture time
    logic               a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign a_neg    = ~op[0] & a[WIDTH-1];
    assign b_neg    = ~op[0] & b[WIDTH-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign div_zero = op[1] & (b == '0);

    // Multiply step: conditional add into upper half, then shift right with carry
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = opb_reg[gi] & prod_reg[0];
        end
    endgenerate

    assign mul_sum  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign mul_next = {mul_sum, prod_reg[WIDTH-1:1]};

    // Restoring divide step on the WIDTH+1-bit shifted partial remainder
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   rem_next, quo_next;

    assign div_shift = {rem_reg, quo_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_reg};
    assign div_ok    = ~div_diff[WIDTH];
    assign rem_next  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quo_next  = {quo_reg[WIDTH-2:0], div_ok};

    // Sign correction applied in FIX
    logic               neg_res, neg_rem;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign neg_res  = ~op_reg[0] & (sa_reg ^ sb_reg);
    assign neg_rem  = ~op_reg[0] & sa_reg;
    assign prod_fix = neg_res ? -prod_reg : prod_reg;
    assign quo_fix  = neg_res ? -quo_reg : quo_reg;
    assign rem_fix  = neg_rem ? -rem_reg : rem_reg;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = div_zero ? FIX : CALC;
            CALC:    if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: control strobes
    always_comb begin
        accept  = 1'b0;
        iterate = 1'b0;
        fix_now = 1'b0;
        hi_load = 1'b0;
        lo_load = 1'b0;
        case (state_reg)
            IDLE: begin
                accept  = start;
                hi_load = ~start & hi_wr;
                lo_load = ~start & lo_wr;
            end
            CALC:    iterate = 1'b1;
            FIX:     fix_now = 1'b1;
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg      <= '0;
            op_reg       <= '0;
            sa_reg       <= 1'b0;
            sb_reg       <= 1'b0;
            dbz_pend_reg <= 1'b0;
            prod_reg     <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            opb_reg      <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            dbz_reg      <= 1'b0;
        end else begin
            busy_reg <= (state_next != IDLE);
            done_reg <= fix_now;
            if (accept) begin
                cnt_reg      <= '0;
                op_reg       <= op;
                sa_reg       <= a_neg;
                sb_reg       <= b_neg;
                dbz_pend_reg <= div_zero;
                dbz_reg      <= 1'b0;
                prod_reg     <= {{WIDTH{1'b0}}, b_mag};
                rem_reg      <= '0;
                // A zero divisor reports the raw dividend in HI, so keep it unmodified
                quo_reg      <= div_zero ? a : a_mag;
                opb_reg      <= op[1] ? b_mag : a_mag;
            end
            if (iterate) begin
                cnt_reg <= cnt_reg + CW'(1);
                if (op_reg[1]) begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                end else begin
                    prod_reg <= mul_next;
                end
            end
            if (fix_now) begin
                if (dbz_pend_reg) begin
                    hi_reg  <= quo_reg;
                    lo_reg  <= '1;
                    dbz_reg <= 1'b1;
                end else if (op_reg[1]) begin
                    hi_reg <= rem_fix;
                    lo_reg <= quo_fix;
                end else begin
                    hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                    lo_reg <= prod_fix[WIDTH-1:0];
                end
            end
            if (hi_load) hi_reg <= wr_data;
            if (lo_load) lo_reg <= wr_data;
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: 32-bit and 8-bit instances share stimulus
// and are compared against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0, b = '0, wr_data = '0;
    logic        hi_wr = 1'b0, lo_wr = 1'b0;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;
    longint unsigned last_hi, last_lo, last_hi8, last_lo8;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
        .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a[7:0]), .b(b[7:0]),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data[7:0]),
        .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on w-bit values
    function automatic void model(input int w, input logic [1:0] o,
                                  input longint unsigned xi, input longint unsigned yi,
                                  output longint unsigned mh, output longint unsigned ml,
                                  output bit mz);
        longint unsigned mask, x, y, pu;
        longint sx, sy, p, q, r;
        mask = (64'd1 << w) - 64'd1;
        x = xi & mask;
        y = yi & mask;
        sx = x[w-1] ? longint'(x) - longint'(64'd1 << w) : longint'(x);
        sy = y[w-1] ? longint'(y) - longint'(64'd1 << w) : longint'(y);
        mz = 1'b0;
        mh = 0;
        ml = 0;
        if (o[1] == 1'b0) begin
            if (o == 2'd0) begin
                p  = sx * sy;
                pu = longint'(p);
            end else begin
                pu = x * y;
            end
            ml = pu & mask;
            mh = (pu >> w) & mask;
        end else if (y == 0) begin
            mh = x;
            ml = mask;
            mz = 1'b1;
        end else if (o == 2'd2) begin
            q  = sx / sy;
            r  = sx % sy;
            ml = longint'(q) & mask;
            mh = longint'(r) & mask;
        end else begin
            ml = (x / y) & mask;
            mh = (x % y) & mask;
        end
    endfunction

    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit lo_too, input bit disturb);
        longint unsigned eh, el, eh8, el8;
        bit ez, ez8, bad, bad8;
        int n, n32, n8, bc, bc8, lat, lat8;
        logic [31:0] h0, l0;
        logic [7:0] h08, l08;
        logic bd, bd8;
        model(32, o, x, y, eh, el, ez);
        model(8, o, x, y, eh8, el8, ez8);
        lat  = ez ? 2 : 34;
        lat8 = ez8 ? 2 : 10;
        @(negedge clk);
        h0 = hi; l0 = lo; h08 = hi8; l08 = lo8;
        start = 1'b1; op = o; a = x; b = y; lo_wr = lo_too; wr_data = 32'h5555_5555;
        @(posedge clk); #1;
        start = 1'b0; lo_wr = 1'b0;
        n = 1; n32 = 0; n8 = 0; bc = 0; bc8 = 0; bad = 1'b0; bad8 = 1'b0; bd = 1'b1; bd8 = 1'b1;
        while (n < 100) begin
            if (n32 == 0) begin
                if (done) begin n32 = n; bd = busy; end
                else begin
                    if (busy) bc++;
                    if (hi !== h0 || lo !== l0) bad = 1'b1;
                end
            end
            if (n8 == 0) begin
                if (done8) begin n8 = n; bd8 = busy8; end
                else begin
                    if (busy8) bc8++;
                    if (hi8 !== h08 || lo8 !== l08) bad8 = 1'b1;
                end
            end
            if (n32 != 0 && n8 != 0) break;
            if (disturb && n == 5) begin
                start = 1'b1; hi_wr = 1'b1; a = ~x; b = ~y; wr_data = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; hi_wr = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0; hi_wr = 1'b0;
        chk("latency32", 64'(n32), 64'(lat));
        chk("busy_cycles32", 64'(bc), 64'(lat - 1));
        chk("busy_at_done32", {63'd0, bd}, 64'd0);
        chk("hold32", {63'd0, bad}, 64'd0);
        chk("hi32", {32'd0, hi}, eh);
        chk("lo32", {32'd0, lo}, el);
        chk("dbz32", {63'd0, dbz}, {63'd0, ez});
        chk("latency8", 64'(n8), 64'(lat8));
        chk("busy_cycles8", 64'(bc8), 64'(lat8 - 1));
        chk("busy_at_done8", {63'd0, bd8}, 64'd0);
        chk("hold8", {63'd0, bad8}, 64'd0);
        chk("hi8", {56'd0, hi8}, eh8);
        chk("lo8", {56'd0, lo8}, el8);
        chk("dbz8", {63'd0, dbz8}, {63'd0, ez8});
        last_hi = eh; last_lo = el; last_hi8 = eh8; last_lo8 = el8;
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b lat=%0d | w8 hi=%h lo=%h lat=%0d",
                 o, x, y, hi, lo, dbz, n32, hi8, lo8, n8);
    endtask

    initial begin
        int seen;
        logic [1:0] ro;
        logic [31:0] rx, ry;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dbz", {63'd0, dbz}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_hi8", {56'd0, hi8}, 64'd0);
        reset = 1'b0;

        // Signed and unsigned multiply
        run(2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0);
        chk("mult_neg_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("mult_neg_lo", {32'd0, lo}, 64'hFFFF_FFF1);
        run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("multu_max_hi", {32'd0, hi}, 64'hFFFF_FFFE);
        chk("multu_max_lo", {32'd0, lo}, 64'h0000_0001);
        run(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        chk("mult_min_hi", {32'd0, hi}, 64'h4000_0000);
        chk("mult_min_lo", {32'd0, lo}, 64'h0);

        // Division sign rules and overflow
        run(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        chk("div_neg_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("div_neg_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        run(2'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        chk("divu_lo", {32'd0, lo}, 64'd14);
        chk("divu_hi", {32'd0, hi}, 64'd2);
        run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div_ovf_lo", {32'd0, lo}, 64'h8000_0000);
        chk("div_ovf_hi", {32'd0, hi}, 64'h0);

        // Narrow instance corner cases
        run(2'd0, 32'h0000_0080, 32'h0000_0080, 1'b0, 1'b0);
        chk("w8_mult_hi", {56'd0, hi8}, 64'h40);
        chk("w8_mult_lo", {56'd0, lo8}, 64'h00);
        run(2'd2, 32'h0000_0080, 32'h0000_00FF, 1'b0, 1'b0);
        chk("w8_div_lo", {56'd0, lo8}, 64'h80);
        chk("w8_div_hi", {56'd0, hi8}, 64'h00);

        // Divide by zero, then a following start clears the flag
        run(2'd3, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
        chk("dbz_hi", {32'd0, hi}, 64'h1234);
        chk("dbz_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        chk("dbz_flag", {63'd0, dbz}, 64'd1);
        run(2'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        chk("dbz_clear", {63'd0, dbz}, 64'd0);
        chk("multu_small_lo", {32'd0, lo}, 64'd6);

        // Busy-time start/MTHI ignored; idle start beats MTLO
        run(2'd0, 32'h0001_2345, 32'hFFFF_FF00, 1'b0, 1'b1);
        run(2'd1, 32'h0BAD_F00D, 32'h0000_0777, 1'b1, 1'b0);

        // MTHI alone, then MTHI+MTLO together
        @(negedge clk); hi_wr = 1'b1; wr_data = 32'h0000_ABCD;
        @(posedge clk); #1; hi_wr = 1'b0;
        chk("mthi_hi", {32'd0, hi}, 64'h0000_ABCD);
        chk("mthi_lo_kept", {32'd0, lo}, last_lo);
        chk("mthi_hi8", {56'd0, hi8}, 64'hCD);
        $display("mthi wr_data=0000abcd -> hi=%h lo=%h", hi, lo);
        @(negedge clk); hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h0000_1357;
        @(posedge clk); #1; hi_wr = 1'b0; lo_wr = 1'b0;
        chk("mthilo_hi", {32'd0, hi}, 64'h1357);
        chk("mthilo_lo", {32'd0, lo}, 64'h1357);
        chk("mthilo_lo8", {56'd0, lo8}, 64'h57);
        $display("mthi+mtlo wr_data=00001357 -> hi=%h lo=%h", hi, lo);

        // Back-to-back: second start issued in the done cycle
        run(2'd3, 32'hFFFF_0000, 32'h0000_0013, 1'b0, 1'b0);
        chk("b2b_done_cycle", {63'd0, done}, 64'd1);
        run(2'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);

        // Randomised operations
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = (i % 6 == 5) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       ry = 32'h0;
                1:       ry = 32'hFFFF_FFFF;
                2:       ry = $urandom_range(1, 15);
                default: ry = $urandom;
            endcase
            run(ro, rx, ry, 1'b0, 1'b0);
        end

        // Reset mid-operation
        run(2'd2, 32'h0000_0055, 32'h0, 1'b0, 1'b0);
        @(negedge clk); start = 1'b1; op = 2'd0; a = 32'h1234_5678; b = 32'h0000_0777;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_dbz", {63'd0, dbz}, 64'd0);
        chk("midrst_hi", {32'd0, hi}, 64'd0);
        chk("midrst_lo", {32'd0, lo}, 64'd0);
        chk("midrst_busy8", {63'd0, busy8}, 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("midrst_quiet", 64'(seen), 64'd0);
        $display("reset mid-op -> busy=%0b hi=%h lo=%h", busy, hi, lo);

        run(2'd1, 32'd9, 32'd11, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
